// File: rtl/mux_rr_arbiter_if.sv
// Shared-mux arbiter bundle: four requesters' req/data, the downstream ready,
// and the arbiter's grant/select/data/valid returned on the same bundle.
interface mux_rr_arbiter_if #(
  parameter int W = 4
);
  logic [3:0]   req;
  logic [W-1:0] D0;
  logic [W-1:0] D1;
  logic [W-1:0] D2;
  logic [W-1:0] D3;
  logic         ready;
  logic [3:0]   grant;
  logic [1:0]   S;
  logic [W-1:0] Y;
  logic         valid;

  // Requesters plus downstream sink drive req/D*/ready.
  modport master (
    output req, D0, D1, D2, D3, ready,
    input  grant, S, Y, valid
  );

  // The arbiter owns grant, the mux select and the forwarded data.
  modport slave (
    input  req, D0, D1, D2, D3, ready,
    output grant, S, Y, valid
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux with burst-length-limited grants.
// Latency: req seen in IDLE gives grant/valid one edge later; one idle cycle between grants.
// Backpressure: ready=0 stalls the burst with Y held; dropping req releases at the next edge.
module mux_rr_arbiter #(
  parameter int W        = 4,
  parameter int MAX_HOLD = 4
) (
  input logic               clk,
  input logic               rst,
  mux_rr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t       state;
  logic [1:0]   ptr;
  logic [3:0]   hold_cnt;
  logic [1:0]   win;
  logic         found;
  logic [1:0]   idx;
  logic [W-1:0] dsel;
  logic         xfer;

  // First requester at or after ptr, wrapping mod 4.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    case (bus.S)
      2'd0:    dsel = bus.D0;
      2'd1:    dsel = bus.D1;
      2'd2:    dsel = bus.D2;
      default: dsel = bus.D3;
    endcase
  end

  assign bus.valid = (state == BUSY) && bus.req[bus.S];
  assign bus.Y     = bus.valid ? dsel : '0;
  assign xfer      = bus.valid && bus.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus.grant <= 4'b0000;
      bus.S     <= 2'd0;
      ptr       <= 2'd0;
      hold_cnt  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= BUSY;
            bus.grant <= 4'b0001 << win;
            bus.S     <= win;
            hold_cnt  <= 4'd0;
          end
        end
        BUSY: begin
          // S is left alone on release; valid=0 already masks Y.
          if (!bus.req[bus.S] || (xfer && hold_cnt == HOLD_LAST)) begin
            state     <= IDLE;
            bus.grant <= 4'b0000;
            ptr       <= bus.S + 2'd1;
            hold_cnt  <= 4'd0;
          end else if (xfer) begin
            hold_cnt  <= hold_cnt + 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          bus.grant <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed checks of the round-robin shared-mux arbiter with W=4, MAX_HOLD=4.
module tb_mux_rr_arbiter;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  mux_rr_arbiter_if #(.W(4)) bus ();

  mux_rr_arbiter #(.W(4), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic v, input logic [3:0] y);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".S"},     32'(bus.S),     32'(s));
    chk({tag, ".valid"}, 32'(bus.valid), 32'(v));
    chk({tag, ".Y"},     32'(bus.Y),     32'(y));
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = 4'b0000;
    tick();
    rst     = 1'b0;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.req   = 4'b0000;
    bus.D0    = 4'h1;
    bus.D1    = 4'h2;
    bus.D2    = 4'h4;
    bus.D3    = 4'h8;
    bus.ready = 1'b1;

    // 1: single requester, full burst, one bubble, regrant
    do_reset();
    chk_out("t1.reset", 4'b0000, 2'd0, 1'b0, 4'h0);
    bus.req = 4'b0001;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("t1.burst%0d", i), 4'b0001, 2'd0, 1'b1, 4'h1);
      tick();
    end
    chk_out("t1.bubble", 4'b0000, 2'd0, 1'b0, 4'h0);
    tick();
    chk_out("t1.regrant", 4'b0001, 2'd0, 1'b1, 4'h1);

    // 2: all requesting, rotation 0,1,2,3,0 with bubbles
    do_reset();
    bus.req = 4'b1111;
    tick();
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 4; j++) begin
        chk_out($sformatf("t2.b%0d.x%0d", b, j), 4'b0001 << b, 2'(b), 1'b1, 4'b0001 << b);
        tick();
      end
      chk_out($sformatf("t2.idle%0d", b), 4'b0000, 2'(b), 1'b0, 4'h0);
      tick();
    end
    chk_out("t2.wrap", 4'b0001, 2'd0, 1'b1, 4'h1);

    // 3: stalls don't count; release after the 4th accepted transfer
    do_reset();
    bus.req = 4'b0100;
    tick();
    for (int c = 0; c < 6; c++) begin
      bus.ready = (c == 1 || c == 2) ? 1'b0 : 1'b1;
      bus.D0    = 4'(c + 3);
      bus.D1    = 4'(c + 9);
      bus.D3    = 4'(15 - c);
      #1;
      chk_out($sformatf("t3.c%0d", c + 1), 4'b0100, 2'd2, 1'b1, 4'h4);
      tick();
    end
    chk_out("t3.released", 4'b0000, 2'd2, 1'b0, 4'h0);
    bus.ready = 1'b1;
    bus.D0    = 4'h1;
    bus.D1    = 4'h2;
    bus.D3    = 4'h8;

    // 4: requester 1 drops req after two transfers
    do_reset();
    bus.req = 4'b1010;
    tick();
    chk_out("t4.x0", 4'b0010, 2'd1, 1'b1, 4'h2);
    tick();
    chk_out("t4.x1", 4'b0010, 2'd1, 1'b1, 4'h2);
    tick();
    bus.req = 4'b1000;
    #1;
    chk_out("t4.drop", 4'b0010, 2'd1, 1'b0, 4'h0);
    tick();
    chk_out("t4.idle", 4'b0000, 2'd1, 1'b0, 4'h0);
    tick();
    chk_out("t4.next3", 4'b1000, 2'd3, 1'b1, 4'h8);

    // 5: reset mid-burst
    do_reset();
    bus.req = 4'b0100;
    tick();
    tick();
    tick();
    chk_out("t5.mid", 4'b0100, 2'd2, 1'b1, 4'h4);
    rst     = 1'b1;
    bus.req = 4'b1111;
    tick();
    chk_out("t5.rst", 4'b0000, 2'd0, 1'b0, 4'h0);
    rst = 1'b0;
    tick();
    chk_out("t5.first", 4'b0001, 2'd0, 1'b1, 4'h1);

    // 6: idle with no requests, then a one-cycle pulse from requester 2
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk_out($sformatf("t6.idle%0d", i), 4'b0000, 2'd0, 1'b0, 4'h0);
      tick();
    end
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b0000;
    #1;
    chk_out("t6.pulse", 4'b0100, 2'd2, 1'b0, 4'h0);
    tick();
    chk_out("t6.release", 4'b0000, 2'd2, 1'b0, 4'h0);
    bus.req = 4'b1111;
    tick();
    chk_out("t6.ptr3", 4'b1000, 2'd3, 1'b1, 4'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
